// File: rtl/microtile_scan_reader.sv
// Round-robin reader for the micro-tile container: drives tile_sel, waits a
// settle window, then captures each tile's output byte into a readable bank.
module microtile_scan_reader #(
  parameter int unsigned NUM_TILES = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned SETTLE    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic [7:0]           tile_out,
  output logic [SEL_W-1:0]     tile_sel,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_TILES-1:0] valid_mask,
  output logic [7:0]           scan_count,
  input  logic [SEL_W-1:0]     rd_addr,
  output logic [7:0]           rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  localparam logic [3:0]       CNT_LAST = 4'(SETTLE - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_TILES - 1);

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     idx, idx_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 cont_r, cont_nxt;
  logic                 done_nxt;
  logic [NUM_TILES-1:0] valid_nxt;
  logic [7:0]           count_nxt;
  logic                 cap_we;
  logic [7:0]           cap [NUM_TILES];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    cont_nxt  = cont_r;
    done_nxt  = 1'b0;
    valid_nxt = valid_mask;
    count_nxt = scan_count;
    cap_we    = 1'b0;

    case (state)
      S_IDLE: begin
        idx_nxt = '0;
        if (start && !abort) begin
          valid_nxt = '0;
          cont_nxt  = continuous;
          cnt_nxt   = '0;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == CNT_LAST) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        cap_we         = 1'b1;
        valid_nxt[idx] = 1'b1;
        cnt_nxt        = '0;
        if (idx == IDX_LAST) begin
          done_nxt  = 1'b1;
          count_nxt = scan_count + 8'd1;
          idx_nxt   = '0;
          state_nxt = cont_r ? S_SETTLE : S_IDLE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_SETTLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // abort overrides everything above, including the capture write
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
      count_nxt = scan_count;
      valid_nxt = valid_mask;
      cap_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      cont_r     <= 1'b0;
      done       <= 1'b0;
      valid_mask <= '0;
      scan_count <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      cont_r     <= cont_nxt;
      done       <= done_nxt;
      valid_mask <= valid_nxt;
      scan_count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_TILES; i++) cap[i] <= '0;
    end else if (cap_we) begin
      cap[idx] <= tile_out;
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_addr) < NUM_TILES) rd_data = cap[rd_addr];
  end

  assign tile_sel = idx;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_microtile_scan_reader.sv
// Directed bench for microtile_scan_reader with a container model that can
// hold its output at 0xFF for a programmable time after each select change.
module tb_microtile_scan_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] tile_out;
  logic [1:0] tile_sel;
  logic       busy;
  logic       done;
  logic [3:0] valid_mask;
  logic [7:0] scan_count;
  logic [1:0] rd_addr = '0;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tile_val [4];
  int         glitch_len = 0;
  int         age = 100;
  logic [1:0] prev_sel = '0;

  microtile_scan_reader #(
    .NUM_TILES(4),
    .SEL_W    (2),
    .SETTLE   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .continuous(continuous),
    .abort     (abort),
    .tile_out  (tile_out),
    .tile_sel  (tile_sel),
    .busy      (busy),
    .done      (done),
    .valid_mask(valid_mask),
    .scan_count(scan_count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // container model: age counts cycles since the select last changed
  always @(posedge clk) begin
    #1;
    if (start || tile_sel != prev_sel) age = 0;
    else if (age < 100) age = age + 1;
    prev_sel = tile_sel;
  end

  assign tile_out = (age < glitch_len) ? 8'hFF : tile_val[tile_sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic set_vals(input logic [7:0] base);
    for (int i = 0; i < 4; i++) tile_val[i] = base + 8'(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // returns at the negedge inside the first SETTLE cycle
  task automatic do_start(input logic cont);
    start = 1'b1;
    continuous = cont;
    @(negedge clk);
    start = 1'b0;
    continuous = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    set_vals(8'hA0);

    // 1: reset state
    do_reset();
    repeat (5) @(negedge clk);
    check("t1_sel", 32'(tile_sel), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_valid", 32'(valid_mask), 32'd0);
    check("t1_count", 32'(scan_count), 32'd0);
    for (int a = 0; a < 4; a++) read_check("t1_rd", 2'(a), 8'h00);

    // 2: one-shot timing
    @(negedge clk);
    do_start(1'b0);
    for (int c = 1; c <= 20; c++) begin
      check("t2_busy", 32'(busy), 32'(c <= 16));
      check("t2_sel", 32'(tile_sel), (c <= 16) ? 32'((c - 1) / 4) : 32'd0);
      check("t2_done", 32'(done), 32'(c == 17));
      @(negedge clk);
    end
    check("t2_valid", 32'(valid_mask), 32'hF);
    check("t2_count", 32'(scan_count), 32'd1);
    for (int a = 0; a < 4; a++) read_check("t2_rd", 2'(a), 8'hA0 + 8'(a));

    // 3: settle window; 2-cycle glitch is tolerated, 4-cycle is not
    set_vals(8'hB0);
    glitch_len = 2;
    @(negedge clk);
    do_start(1'b0);
    wait_idle("t3a_timeout");
    for (int a = 0; a < 4; a++) read_check("t3a_rd", 2'(a), 8'hB0 + 8'(a));
    glitch_len = 4;
    @(negedge clk);
    do_start(1'b0);
    wait_idle("t3b_timeout");
    for (int a = 0; a < 4; a++) read_check("t3b_rd", 2'(a), 8'hFF);
    glitch_len = 0;

    // 4: continuous, tile 2 changes during pass 2
    do_reset();
    set_vals(8'hC0);
    do_start(1'b1);
    for (int c = 1; c <= 49; c++) begin
      if (c == 20) tile_val[2] = 8'h5C;
      if (c == 17) read_check("t4_cap2_p1", 2'd2, 8'hC2);
      if (c == 33) read_check("t4_cap2_p2", 2'd2, 8'h5C);
      check("t4_done", 32'(done), 32'(c == 17 || c == 33 || c == 49));
      check("t4_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("t4_count", 32'(scan_count - 8'd0), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_abort_busy", 32'(busy), 32'd0);
    check("t4_abort_count", 32'(scan_count), 32'd3);

    // 5: abort in CAPTURE of tile 1
    do_reset();
    set_vals(8'hD0);
    do_start(1'b0);
    wait_idle("t5_timeout");
    set_vals(8'hE0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t5_start_abort_idle", 32'(busy), 32'd0);
    @(negedge clk);
    do_start(1'b0);
    for (int c = 1; c < 8; c++) @(negedge clk);
    read_check("t5_rd_old", 2'd1, 8'hD1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_valid", 32'(valid_mask), 32'h1);
    check("t5_count", 32'(scan_count), 32'd1);
    read_check("t5_cap0", 2'd0, 8'hE0);
    read_check("t5_cap1", 2'd1, 8'hD1);
    repeat (3) begin
      @(negedge clk);
      check("t5_no_done", 32'(done), 32'd0);
    end
    do_start(1'b0);
    check("t5_restart_valid", 32'(valid_mask), 32'h0);
    wait_idle("t5b_timeout");

    // 6: start while busy is ignored (continuous not re-sampled)
    do_reset();
    set_vals(8'hA0);
    do_start(1'b0);
    for (int c = 1; c <= 18; c++) begin
      if (c == 5) begin start = 1'b1; continuous = 1'b1; end
      if (c == 6) begin start = 1'b0; continuous = 1'b0; end
      check("t6_busy", 32'(busy), 32'(c <= 16));
      check("t6_done", 32'(done), 32'(c == 17));
      @(negedge clk);
    end
    check("t6_count", 32'(scan_count), 32'd1);

    // reset mid-scan clears everything immediately
    do_start(1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(valid_mask), 32'd0);
    check("t6_rst_count", 32'(scan_count), 32'd0);
    read_check("t6_rst_cap0", 2'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // scan_count wraps on the 256th pass
    do_start(1'b1);
    n = 0;
    for (int c = 0; c < 5000 && n < 256; c++) begin
      if (done) begin
        n++;
        if (n == 1) check("t6_wrap_1", 32'(scan_count), 32'd1);
        if (n == 255) check("t6_wrap_255", 32'(scan_count), 32'd255);
        if (n == 256) check("t6_wrap_0", 32'(scan_count), 32'd0);
      end
      @(negedge clk);
    end
    if (n < 256) check("t6_wrap_timeout", 32'(n), 32'd256);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/microtile_scan_reader.md
Name: microtile_scan_reader

Overview:
- Host-side reader for the micro-tile container. It drives the 2-bit tile select into the container and samples the container's muxed 8-bit output bus.
- Steps round-robin through all tiles. After each select change it waits a settle window, then captures that tile's output byte into a per-tile register bank.
- Captured bytes are exposed through a random-access read port, with per-tile valid flags and a scan-complete pulse.
- Supports one-shot and continuous scanning, plus a synchronous abort.

Parameters:
- NUM_TILES, 4, number of tiles scanned; legal range 2..4.
- SEL_W, 2, width of the tile-select and read-address buses.
- SETTLE, 3, cycles held on a new select before capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a scan; honoured only in IDLE.
- continuous  in  1  sampled with start; 1 = rescan forever, 0 = one pass.
- abort  in  1  synchronous stop; returns to IDLE.
- tile_out  in  8  muxed tile output bus from the container.
- tile_sel  out  SEL_W  tile select driven into the container.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the last tile of a pass is captured.
- valid_mask  out  NUM_TILES  bit i set once cap[i] holds a byte from the current scan.
- scan_count  out  8  completed passes, wraps 255->0.
- rd_addr  in  SEL_W  capture-bank read index.
- rd_data  out  8  combinational cap[rd_addr]; 0x00 if rd_addr >= NUM_TILES.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, cnt=0, cont_r=0.
  - tile_sel=0, busy=0, done=0, valid_mask=0, scan_count=0.
  - All cap[i]=0x00.
- Everything else is synchronous to the clk rising edge.
- tile_sel always equals the registered idx.
- States:
  - IDLE: busy=0, idx=0. If start=1 (and abort=0): clear valid_mask, latch cont_r<=continuous, cnt<=0, go to SETTLE.
  - SETTLE: cnt<=cnt+1. When cnt==SETTLE-1, go to CAPTURE.
  - CAPTURE:
    - cap[idx]<=tile_out and valid_mask[idx]<=1.
    - If idx<NUM_TILES-1: idx<=idx+1, cnt<=0, go to SETTLE.
    - If idx==NUM_TILES-1: done<=1 for the next cycle, scan_count<=scan_count+1, idx<=0, cnt<=0. Go to SETTLE if cont_r=1, else IDLE.
- Timing:
  - Each tile occupies SETTLE+1 cycles (SETTLE settle cycles plus 1 capture cycle).
  - tile_out is sampled exactly SETTLE cycles after tile_sel changes.
  - One pass takes NUM_TILES*(SETTLE+1) cycles from the first SETTLE cycle.
  - done is asserted in the cycle after the final CAPTURE.
- Continuous mode:
  - valid_mask is not re-cleared between passes.
  - cap entries are overwritten in place.
- abort:
  - From any non-IDLE state: next state IDLE, idx<=0, cnt<=0, no done pulse, scan_count unchanged.
  - cap and valid_mask are retained.
  - abort has priority over start and over the CAPTURE write in the same cycle; that tile's byte is not captured.
- start while busy is ignored; continuous is not re-sampled.
- start and abort together in IDLE: remain in IDLE.
- rd_data is purely combinational. A read of the tile being captured returns the old value that cycle and the new value the next cycle.
- Reset asserted mid-scan forces all reset values immediately, including clearing cap.

Test Plan:
1. Reset, then idle 5 cycles -> tile_sel=0, busy=0, done=0, valid_mask=0000, scan_count=0, rd_data=0x00 for all addresses.
2. One-shot scan with SETTLE=3, NUM_TILES=4, tile_out driven to 0xA0+tile_sel; pulse start with continuous=0 ->
   - busy high for 16 cycles;
   - tile_sel sequence 0,1,2,3 with 4 cycles each;
   - done pulses once on cycle 17;
   - valid_mask=1111, scan_count=1;
   - reading addresses 0..3 returns 0xA0, 0xA1, 0xA2, 0xA3.
3. Settle check: tile_out shows the new tile value only 2 cycles after the tile_sel change, otherwise 0xFF -> all captures still correct (sampled at SETTLE=3). Re-run with the glitch lengthened to 4 cycles -> captures read 0xFF.
4. Continuous scan of 3 passes, with tile 2's value changed to 0x5C during pass 2 ->
   - 3 done pulses spaced 16 cycles apart;
   - scan_count=3;
   - cap[2]=0x5C after pass 2;
   - busy stays high.
5. Abort asserted in the CAPTURE cycle of tile 1 during pass 1 ->
   - IDLE next cycle, no done;
   - valid_mask=0001, cap[1] unchanged;
   - scan_count unchanged;
   - a following start clears valid_mask to 0000.
6. start pulsed while busy, plus scan_count rolloff -> the pass is unaffected. Force 256 continuous passes -> scan_count wraps to 0 on the 256th done pulse.
